hc595_scan_driver: RTL and testbench
====================================

// Module: hc595_scan_driver
// PURPOSE
//   Parametrised multiplexed 7-segment scan driver for a chain of 74HC595 shift registers.
//   Generalises the fixed 8-digit, 40 kHz driver with:
//     - N_DIG digits and a selectable serial clock rate;
//     - segment and digit polarity options;
//     - double-buffered (tear-free) data update, frame-done pulse and a single clock domain.
//   Sits between the display data sources (counters, detectors) and the board 74HC595 pins.
// PARAMETERS
//   N_DIG       8    number of digits scanned (1..16); digit-select field width
//   TICK_DIV    150  clk cycles per scan tick (>=2); sck period = 2 ticks
//   SEG_ACT_LOW 0    1: segment/dot bits inverted before shifting (common anode)
//   DIG_ACT_LOW 1    1: active digit-select bit is 0, idle bits 1
// PORTS
//   clk         in   1        system clock
//   rst_n       in   1        asynchronous active-low reset
//   dat         in   4*N_DIG  hex code per digit, digit i = dat[4*i+3:4*i]
//   dat_en      in   N_DIG    digit i shown when bit i = 1
//   dot_en      in   N_DIG    decimal point of digit i lit when bit i = 1
//   upd         in   1        1-clk pulse: capture dat/dat_en/dot_en into shadow regs
//   frame_done  out  1        1-clk pulse after last digit latched
//   sck         out  1        74HC595 shift clock
//   rck         out  1        74HC595 storage (latch) clock
//   din         out  1        74HC595 serial data (SER)
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; digit index 0; tick counter 0; pending 0.
//   Reset: shadow regs cleared (dat 0, dat_en 0, dot_en 0 -> display blank).
//   Tick: tick counter 0..TICK_DIV-1, wraps; tick = 1-clk enable at count TICK_DIV-1.
//     All FSM, sck, rck and din changes occur only on tick; single clk domain, no derived clocks.
//   Shift word W = 8+N_DIG bits, sent MSB first:
//     W = {dot, G,F,E,D,C,B,A, sel[N_DIG-1:0]}.
//     Font (GFEDCBA): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//     SEG_ACT_LOW inverts the 8 segment bits.
//     sel: only bit i active for digit i (polarity per DIG_ACT_LOW).
//   Disabled digit (dat_en[i]=0): sel all inactive; segment bits all off (polarity applied).
//   FSM, one transition per tick:
//     IDLE  -> LOAD.
//     LOAD: build W for current digit; bit counter = W-1.
//       At digit 0, apply pending shadow update first.
//     SHIFT_L: sck=0, din=W[bit].
//     SHIFT_H: sck=1; if bit=0 -> LATCH_H, else bit-- and -> SHIFT_L.
//     LATCH_H: rck=1.
//     LATCH_L: rck=0; digit = (digit==N_DIG-1) ? 0 : digit+1; -> LOAD.
//       frame_done pulses on this tick when the wrapped digit was N_DIG-1.
//   Per-digit cost: 1 + 2W + 2 ticks. N_DIG=8, TICK_DIV=150: 35 ticks = 5250 clk per digit.
//   Update: upd copies inputs into a staging reg and sets pending.
//     Staging content goes live only at the next digit-0 LOAD, so a frame is never mixed.
//     upd while pending: staging overwritten, last write wins.
//     upd on the same clk as the digit-0 LOAD tick: the new value is used in that frame.
//   Reset mid-frame: outputs drop to 0 immediately (async); restart at IDLE, digit 0.
// TESTING
//   1. Reset, N_DIG=8, TICK_DIV=4, upd with dat=32'h76543210, dat_en=FF, dot_en=00.
//      -> digit 0 shifts 16'h3FFE, digit 7 shifts 16'h077F, MSB first.
//   2. dat_en=8'b0000_0100 -> only digit 2 word has sel=FB; other words = 16'h00FF.
//   3. SEG_ACT_LOW=1, DIG_ACT_LOW=0, digit 0 = 8 with dot -> shifted word 16'h0001.
//   4. upd mid-frame (digit 3) changing all data -> digits 3..7 keep old values.
//      New values appear from next digit 0; frame_done pulses exactly once per frame.
//   5. Timing: sck high/low = TICK_DIV clk each.
//      - din stable across every sck rise; rck high 1 tick after 16th sck rise.
//      - period = 35*TICK_DIV per digit.
//   6. Assert rst_n low during SHIFT_H of digit 5.
//      -> sck/rck/din 0 same cycle; after release, first word sent is digit 0.

Source files
------------

// File: rtl/hc595_scan_driver.sv
// hc595_scan_driver
//   Multiplexed 7-segment scan driver for a chain of 74HC595 shift registers.
//   Each digit is sent as one word {dot, G..A, sel[N_DIG-1:0]}, MSB first, then
//   latched with rck. Display data is double buffered: upd loads a staging copy,
//   and that copy goes live only when digit 0 is loaded, so a frame never mixes
//   old and new data.
// Ports
//   clk, rst_n  system clock, asynchronous active-low reset
//   dat         4-bit hex code per digit, digit i = dat[4*i+3:4*i]
//   dat_en      digit i displayed when bit i = 1
//   dot_en      decimal point of digit i lit when bit i = 1
//   upd         1-clk pulse capturing dat/dat_en/dot_en into the staging regs
//   frame_done  1-clk pulse after the last digit of a frame is latched
//   sck/rck/din 74HC595 shift clock, storage clock and serial data
module hc595_scan_driver #(
  parameter int N_DIG       = 8,
  parameter int TICK_DIV    = 150,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*N_DIG-1:0] dat,
  input  logic [N_DIG-1:0]   dat_en,
  input  logic [N_DIG-1:0]   dot_en,
  input  logic               upd,
  output logic               frame_done,
  output logic               sck,
  output logic               rck,
  output logic               din
);

  localparam int W  = 8 + N_DIG;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int BW = $clog2(W);

  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [DW-1:0] DIG_MAX  = DW'(N_DIG - 1);
  localparam logic [DW-1:0] DIG_ZERO = {DW{1'b0}};
  localparam logic [BW-1:0] BIT_MAX  = BW'(W - 1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT_L = 3'd2,
    SHIFT_H = 3'd3,
    LATCH_H = 3'd4,
    LATCH_L = 3'd5
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [CW-1:0]        cnt_r;
  logic                 tick_s;
  logic [DW-1:0]        digit_r;
  logic [BW-1:0]        bit_r;
  logic [W-1:0]         word_r, word_s;
  logic [4*N_DIG-1:0]   live_dat_r, stg_dat_r, src_dat_s;
  logic [N_DIG-1:0]     live_en_r, stg_en_r, src_en_s;
  logic [N_DIG-1:0]     live_dot_r, stg_dot_r, src_dot_s;
  logic                 pending_r;
  logic                 load0_s;
  logic [3:0]           nib_s;
  logic [7:0]           seg_s;
  logic [N_DIG-1:0]     sel_s;
  logic                 sck_r, rck_r, din_r, fd_r;
  logic                 sck_nxt_s, rck_nxt_s, din_nxt_s, fd_nxt_s;

  // Hex code to GFEDCBA segment pattern, active high.
  function automatic logic [6:0] seg_font(input logic [3:0] code);
    case (code)
      4'h0:    seg_font = 7'h3F;
      4'h1:    seg_font = 7'h06;
      4'h2:    seg_font = 7'h5B;
      4'h3:    seg_font = 7'h4F;
      4'h4:    seg_font = 7'h66;
      4'h5:    seg_font = 7'h6D;
      4'h6:    seg_font = 7'h7D;
      4'h7:    seg_font = 7'h07;
      4'h8:    seg_font = 7'h7F;
      4'h9:    seg_font = 7'h6F;
      4'hA:    seg_font = 7'h77;
      4'hB:    seg_font = 7'h7C;
      4'hC:    seg_font = 7'h39;
      4'hD:    seg_font = 7'h5E;
      4'hE:    seg_font = 7'h79;
      4'hF:    seg_font = 7'h71;
      default: seg_font = 7'h00;
    endcase
  endfunction

  assign tick_s  = (cnt_r == CNT_MAX);
  assign load0_s = tick_s && (state_r == LOAD) && (digit_r == DIG_ZERO);

  // Scan tick prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (tick_s) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Data source for the word being built: at digit 0 a same-clock upd or a
  // pending staging copy takes precedence over the live copy.
  always_comb begin
    if ((digit_r == DIG_ZERO) && upd) begin
      src_dat_s = dat;
      src_en_s  = dat_en;
      src_dot_s = dot_en;
    end else if ((digit_r == DIG_ZERO) && pending_r) begin
      src_dat_s = stg_dat_r;
      src_en_s  = stg_en_r;
      src_dot_s = stg_dot_r;
    end else begin
      src_dat_s = live_dat_r;
      src_en_s  = live_en_r;
      src_dot_s = live_dot_r;
    end
  end

  // Shift word for the current digit, polarity applied last.
  always_comb begin
    nib_s = src_dat_s[{digit_r, 2'b00} +: 4];
    seg_s = 8'h00;
    sel_s = {N_DIG{1'b0}};
    if (src_en_s[digit_r]) begin
      seg_s          = {src_dot_s[digit_r], seg_font(nib_s)};
      sel_s[digit_r] = 1'b1;
    end else begin
      seg_s = 8'h00;
      sel_s = {N_DIG{1'b0}};
    end
    word_s = {seg_s ^ {8{SEG_ACT_LOW}}, sel_s ^ {N_DIG{DIG_ACT_LOW}}};
  end

  // Staging and live display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_dat_r  <= {(4*N_DIG){1'b0}};
      stg_en_r   <= {N_DIG{1'b0}};
      stg_dot_r  <= {N_DIG{1'b0}};
      live_dat_r <= {(4*N_DIG){1'b0}};
      live_en_r  <= {N_DIG{1'b0}};
      live_dot_r <= {N_DIG{1'b0}};
      pending_r  <= 1'b0;
    end else begin
      if (upd) begin
        stg_dat_r <= dat;
        stg_en_r  <= dat_en;
        stg_dot_r <= dot_en;
      end
      // src_* already folds in a same-clock upd, so the staging copy is consumed.
      if (load0_s) begin
        live_dat_r <= src_dat_s;
        live_en_r  <= src_en_s;
        live_dot_r <= src_dot_s;
        pending_r  <= 1'b0;
      end else if (upd) begin
        pending_r  <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state, one transition per tick.
  always_comb begin
    state_nxt_s = state_r;
    if (tick_s) begin
      case (state_r)
        IDLE:    state_nxt_s = LOAD;
        LOAD:    state_nxt_s = SHIFT_L;
        SHIFT_L: state_nxt_s = SHIFT_H;
        SHIFT_H: state_nxt_s = (bit_r == BIT_ZERO) ? LATCH_H : SHIFT_L;
        LATCH_H: state_nxt_s = LATCH_L;
        LATCH_L: state_nxt_s = LOAD;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next output values; pins change only on a tick.
  always_comb begin
    sck_nxt_s = sck_r;
    rck_nxt_s = rck_r;
    din_nxt_s = din_r;
    fd_nxt_s  = 1'b0;
    if (tick_s) begin
      sck_nxt_s = (state_nxt_s == SHIFT_H);
      rck_nxt_s = (state_nxt_s == LATCH_H);
      case (state_r)
        LOAD:    din_nxt_s = word_s[BIT_MAX];
        SHIFT_H: din_nxt_s = (bit_r == BIT_ZERO) ? din_r : word_r[bit_r - 1'b1];
        LATCH_L: fd_nxt_s  = (digit_r == DIG_MAX);
        default: din_nxt_s = din_r;
      endcase
    end else begin
      sck_nxt_s = sck_r;
      rck_nxt_s = rck_r;
      din_nxt_s = din_r;
      fd_nxt_s  = 1'b0;
    end
  end

  // Registered output pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_r <= 1'b0;
      rck_r <= 1'b0;
      din_r <= 1'b0;
      fd_r  <= 1'b0;
    end else begin
      sck_r <= sck_nxt_s;
      rck_r <= rck_nxt_s;
      din_r <= din_nxt_s;
      fd_r  <= fd_nxt_s;
    end
  end

  // Word, bit counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r  <= {W{1'b0}};
      bit_r   <= BIT_ZERO;
      digit_r <= DIG_ZERO;
    end else if (tick_s) begin
      case (state_r)
        LOAD: begin
          word_r <= word_s;
          bit_r  <= BIT_MAX;
        end
        SHIFT_H: begin
          if (bit_r != BIT_ZERO) begin
            bit_r <= bit_r - 1'b1;
          end
        end
        LATCH_L: digit_r <= (digit_r == DIG_MAX) ? DIG_ZERO : digit_r + 1'b1;
        default: ;
      endcase
    end
  end

  assign sck        = sck_r;
  assign rck        = rck_r;
  assign din        = din_r;
  assign frame_done = fd_r;

endmodule

// File: tb/tb_hc595_scan_driver.sv
module tb_hc595_scan_driver;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dat = 32'h0;
  logic [7:0]  dat_en = 8'h00;
  logic [7:0]  dot_en = 8'h00;
  logic        upd = 1'b0;
  logic        frame_done, sck, rck, din;
  logic        frame_done2, sck2, rck2, din2;

  int checks = 0;
  int errors = 0;

  logic [6:0]  font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [15:0] exp_q [$];
  logic [15:0] exp2_q [$];
  logic [15:0] rx2 [$];
  bit          chk_on = 1'b0;
  bit          tchk_on = 1'b0;
  int          clk_cnt = 0;
  int          rck_cnt = 0;
  int          fd_cnt = 0;

  hc595_scan_driver #(.N_DIG(8), .TICK_DIV(TD), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .dat(dat), .dat_en(dat_en), .dot_en(dot_en), .upd(upd),
    .frame_done(frame_done), .sck(sck), .rck(rck), .din(din));

  hc595_scan_driver #(.N_DIG(8), .TICK_DIV(TD), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .dat(dat), .dat_en(dat_en), .dot_en(dot_en), .upd(upd),
    .frame_done(frame_done2), .sck(sck2), .rck(rck2), .din(din2));

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_word(input logic [31:0] d, input logic [7:0] e,
                                           input logic [7:0] o, input int i,
                                           input bit seg_low, input bit dig_low);
    logic [7:0] seg;
    logic [7:0] sel;
    logic [7:0] one;
    one = 8'h01;
    if (e[i]) begin
      seg = {o[i], font_tab[d[4*i +: 4]]};
      sel = one << i;
    end else begin
      seg = 8'h00;
      sel = 8'h00;
    end
    if (seg_low) seg = ~seg;
    if (dig_low) sel = ~sel;
    return {seg, sel};
  endfunction

  // Monitor for the main instance: rebuilds words, scoreboards them, checks timing.
  initial begin
    logic [15:0] sh;
    logic [15:0] w;
    logic sck_q, rck_q, din_q, fd_q;
    int nbits, t_rise, t_rck;
    sh = 16'h0; sck_q = 1'b0; rck_q = 1'b0; din_q = 1'b0; fd_q = 1'b0;
    nbits = 0; t_rise = -1; t_rck = -1;
    forever begin
      @(negedge clk);
      clk_cnt++;
      if (!rst_n) begin
        sh = 16'h0; nbits = 0; t_rise = -1; t_rck = -1;
        sck_q = 1'b0; rck_q = 1'b0; din_q = 1'b0; fd_q = 1'b0;
      end else begin
        if (sck && !sck_q) begin
          if (tchk_on) begin
            checks++;
            if (din !== din_q) begin
              errors++;
              $display("FAIL din_stable: din %b at sck rise, %b one clk before", din, din_q);
            end
            if (nbits > 0) begin
              checks++;
              if (clk_cnt - t_rise !== 2*TD) begin
                errors++;
                $display("FAIL sck_period: got %0d clk, want %0d", clk_cnt - t_rise, 2*TD);
              end
            end
          end
          sh = {sh[14:0], din};
          nbits++;
          t_rise = clk_cnt;
        end
        if (!sck && sck_q && tchk_on) begin
          checks++;
          if (clk_cnt - t_rise !== TD) begin
            errors++;
            $display("FAIL sck_high: got %0d clk, want %0d", clk_cnt - t_rise, TD);
          end
        end
        if (rck && !rck_q) begin
          if (tchk_on) begin
            checks++;
            if (nbits !== 16 || clk_cnt - t_rise !== TD) begin
              errors++;
              $display("FAIL rck_timing: bits %0d delay %0d, want 16 bits delay %0d",
                       nbits, clk_cnt - t_rise, TD);
            end
            if (t_rck >= 0) begin
              checks++;
              if (clk_cnt - t_rck !== 35*TD) begin
                errors++;
                $display("FAIL digit_period: got %0d clk, want %0d", clk_cnt - t_rck, 35*TD);
              end
            end
          end
          if (chk_on) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL word_unexpected: got %h, no word expected", sh);
            end else begin
              w = exp_q.pop_front();
              if (sh !== w) begin
                errors++;
                $display("FAIL word: got %h, want %h", sh, w);
              end
            end
          end
          rck_cnt++;
          t_rck = clk_cnt;
          nbits = 0;
        end
        if (frame_done) begin
          fd_cnt++;
          if (tchk_on) begin
            checks++;
            if (fd_q !== 1'b0) begin
              errors++;
              $display("FAIL frame_done_width: high %b on consecutive clks, want 1 clk", fd_q);
            end
          end
        end
        sck_q = sck; rck_q = rck; din_q = din; fd_q = frame_done;
      end
    end
  end

  // Monitor for the inverted-polarity instance: collects latched words.
  initial begin
    logic [15:0] sh2;
    logic sck2_q, rck2_q;
    sh2 = 16'h0; sck2_q = 1'b0; rck2_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sh2 = 16'h0; sck2_q = 1'b0; rck2_q = 1'b0;
      end else begin
        if (sck2 && !sck2_q) sh2 = {sh2[14:0], din2};
        if (rck2 && !rck2_q) rx2.push_back(sh2);
        sck2_q = sck2; rck2_q = rck2;
      end
    end
  end

  task automatic do_upd(input logic [31:0] d, input logic [7:0] e, input logic [7:0] o);
    @(negedge clk);
    dat = d; dat_en = e; dot_en = o; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic wait_fd();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk); #1;
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL frame_done_timeout: got no pulse, want one within 3000 clk");
    end
  endtask

  task automatic wait_rck(input int n);
    int start;
    start = rck_cnt;
    for (int i = 0; i < 2000 && rck_cnt < start + n; i++) begin
      @(negedge clk); #1;
    end
    if (rck_cnt < start + n) begin
      checks++; errors++;
      $display("FAIL rck_timeout: got %0d latches, want %0d", rck_cnt - start, n);
    end
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [7:0] e, input logic [7:0] o);
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_word(d, e, o, i, 1'b0, 1'b1));
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d words left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sck, rck, din, frame_done, sck2, rck2, din2, frame_done2} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 00000000",
               {sck, rck, din, frame_done, sck2, rck2, din2, frame_done2});
    end
    push_frame(32'h0, 8'h00, 8'h00);
    chk_on = 1'b1;
    #1 rst_n = 1'b1;
    tchk_on = 1'b1;
    wait_fd();
    chk_on = 1'b0;
    check_drained("reset_blank_frame");
  endtask

  task automatic test_frame(input logic [31:0] d, input logic [7:0] e, input logic [7:0] o,
                            input string name);
    do_upd(d, e, o);
    wait_fd();
    push_frame(d, e, o);
    chk_on = 1'b1;
    wait_fd();
    chk_on = 1'b0;
    check_drained(name);
  endtask

  task automatic test_last_write_wins();
    wait_fd();
    wait_rck(1);
    do_upd(32'h01234567, 8'hFF, 8'hFF);
    do_upd(32'h89ABCDEF, 8'hF0, 8'h0F);
    wait_fd();
    push_frame(32'h89ABCDEF, 8'hF0, 8'h0F);
    chk_on = 1'b1;
    wait_fd();
    chk_on = 1'b0;
    check_drained("last_write_wins");
  endtask

  task automatic test_upd_at_load();
    wait_fd();
    repeat (2) @(negedge clk);
    do_upd(32'h13579BDF, 8'hFF, 8'h55);
    push_frame(32'h13579BDF, 8'hFF, 8'h55);
    chk_on = 1'b1;
    wait_fd();
    chk_on = 1'b0;
    check_drained("upd_at_load");
  endtask

  task automatic test_mid_frame();
    int fd0, rck0;
    wait_fd();
    fd0 = fd_cnt;
    rck0 = rck_cnt;
    push_frame(32'h13579BDF, 8'hFF, 8'h55);
    push_frame(32'h2468ACE0, 8'hFF, 8'hAA);
    chk_on = 1'b1;
    wait_rck(3);
    do_upd(32'h2468ACE0, 8'hFF, 8'hAA);
    wait_fd();
    wait_fd();
    chk_on = 1'b0;
    check_drained("mid_frame");
    checks++;
    if (fd_cnt - fd0 !== 2 || rck_cnt - rck0 !== 16) begin
      errors++;
      $display("FAIL frame_done_count: got %0d pulses over %0d words, want 2 over 16",
               fd_cnt - fd0, rck_cnt - rck0);
    end
  endtask

  task automatic test_polarity();
    logic [15:0] got, want;
    do_upd(32'h76543218, 8'hFF, 8'h01);
    exp2_q.push_back(exp_word(32'h76543218, 8'hFF, 8'h01, 0, 1'b1, 1'b0));
    exp2_q.push_back(exp_word(32'h76543218, 8'hFF, 8'h01, 1, 1'b1, 1'b0));
    wait_fd();
    rx2.delete();
    for (int i = 0; i < 1000 && rx2.size() < 2; i++) @(negedge clk);
    while (exp2_q.size() > 0) begin
      want = exp2_q.pop_front();
      checks++;
      if (rx2.size() == 0) begin
        errors++;
        $display("FAIL polarity_timeout: got no word, want %h", want);
      end else begin
        got = rx2.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL polarity_word: got %h, want %h", got, want);
        end
      end
    end
    checks++;
    if (want !== 16'hF902) begin
      errors++;
      $display("FAIL polarity_model: got %h, want F902", want);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit hi;
    wait_fd();
    wait_rck(5);
    hi = 1'b0;
    for (int i = 0; i < 200 && !hi; i++) begin
      @(negedge clk); #1;
      if (sck) hi = 1'b1;
    end
    checks++;
    if (!hi) begin
      errors++;
      $display("FAIL shift_h_timeout: sck got 0, want 1 in digit 5");
    end
    tchk_on = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sck, rck, din, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: got %b, want 0000", {sck, rck, din, frame_done});
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tchk_on = 1'b1;
    push_frame(32'h76543210, 8'hFF, 8'h00);
    chk_on = 1'b1;
    do_upd(32'h76543210, 8'hFF, 8'h00);
    wait_fd();
    chk_on = 1'b0;
    check_drained("restart_digit0");
  endtask

  initial begin
    test_reset();
    test_frame(32'h76543210, 8'hFF, 8'h00, "frame_all_on");
    test_frame(32'h76543210, 8'h04, 8'h00, "frame_one_digit");
    test_last_write_wins();
    test_upd_at_load();
    test_mid_frame();
    test_polarity();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
